// File: rtl/regfl_rdr.sv
// regfl_rdr: snapshots the 7x13 register file read bus and streams a wrapped run of words.
// Build option REGFL_RDR_SKIP_ZERO_EN: zero-valued words are dropped without a handshake.
module regfl_rdr #(
    parameter int W = 13,
    parameter int N = 7
) (
    input  logic           clk,
    input  logic           rst_b,
    input  logic           start,
    input  logic [2:0]     first_idx,
    input  logic [3:0]     num,
    input  logic [N*W-1:0] q_in,
    output logic           out_vld,
    input  logic           out_rdy,
    output logic [W-1:0]   out_d,
    output logic [2:0]     out_idx,
    output logic           busy,
    output logic           done
);
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
    localparam logic [3:0] NUM_MAX = 4'(N);
    localparam logic [2:0] IDX_LAST = 3'(N - 1);
    state_t state;
    logic [N*W-1:0] snap;
    logic [2:0] idx;
    logic [3:0] rem;
    logic [3:0] num_c;
    logic [W-1:0] word;
    logic adv;
    assign num_c = (num > NUM_MAX) ? NUM_MAX : num;
    assign word = snap[W*idx +: W];
`ifdef REGFL_RDR_SKIP_ZERO_EN
    assign out_vld = (state == SEND) && (word != '0);
    assign adv = (state == SEND) && (out_rdy || word == '0);
`else
    assign out_vld = (state == SEND);
    assign adv = out_vld && out_rdy;
`endif
    assign out_d = out_vld ? word : '0;
    assign out_idx = (state == SEND) ? idx : 3'd0;
    assign busy = (state != IDLE);
    assign done = (state == DONE);
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
            snap <= '0;
            idx <= '0;
            rem <= '0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    snap <= q_in;
                    idx <= ({1'b0, first_idx} >= NUM_MAX) ? 3'd0 : first_idx;
                    rem <= num_c;
                    state <= (num_c != 4'd0) ? SEND : DONE;
                end
                SEND: if (adv) begin
                    idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
                    rem <= rem - 4'd1;
                    if (rem == 4'd1) state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_regfl_rdr.sv
// tb_regfl_rdr: directed checks of regfl_rdr sequencing, wrap, clamp, stall, reset and zero handling.
module tb_regfl_rdr;
    logic clk = 1'b0;
    logic rst_b;
    logic start;
    logic [2:0] first_idx;
    logic [3:0] num;
    logic [90:0] q_in;
    logic out_vld;
    logic out_rdy;
    logic [12:0] out_d;
    logic [2:0] out_idx;
    logic busy;
    logic done;
    logic [12:0] w [7];
    int total = 0;
    int bad = 0;
    logic [12:0] gd[$];
    logic [2:0] gi[$];
    logic [12:0] exp_d[$];
    logic [2:0] exp_i[$];
    int done_at;

    regfl_rdr dut (
        .clk(clk), .rst_b(rst_b), .start(start), .first_idx(first_idx), .num(num),
        .q_in(q_in), .out_vld(out_vld), .out_rdy(out_rdy), .out_d(out_d),
        .out_idx(out_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    for (genvar k = 0; k < 7; k++) begin : g_q
        assign q_in[13*k +: 13] = w[k];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, want);
        end
    endtask

    task automatic load_words();
        w = '{13'h11A7, 13'h1F3B, 13'h01BC, 13'h122C, 13'h096A, 13'h1247, 13'h0410};
    endtask

    task automatic start_run(input logic [2:0] fi, input logic [3:0] n);
        start = 1'b1;
        first_idx = fi;
        num = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic collect();
        gd.delete();
        gi.delete();
        done_at = -1;
        for (int c = 0; c < 40; c++) begin
            if (out_vld && out_rdy) begin
                gd.push_back(out_d);
                gi.push_back(out_idx);
            end
            if (done) begin
                done_at = c;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic check_seq(input string tag, input int edone);
        chk({tag, "_count"}, gd.size(), exp_d.size());
        for (int i = 0; i < gd.size() && i < exp_d.size(); i++) begin
            chk($sformatf("%s_d%0d", tag, i), {19'd0, gd[i]}, {19'd0, exp_d[i]});
            chk($sformatf("%s_idx%0d", tag, i), {29'd0, gi[i]}, {29'd0, exp_i[i]});
        end
        chk({tag, "_done_at"}, done_at, edone);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, {31'd0, done}, 0);
        chk({tag, "_idle"}, {31'd0, busy}, 0);
    endtask

    initial begin
        rst_b = 1'b0;
        start = 1'b0;
        first_idx = '0;
        num = '0;
        out_rdy = 1'b1;
        load_words();
        #3;
        chk("rst_vld", {31'd0, out_vld}, 0);
        chk("rst_d", {19'd0, out_d}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b1;
        @(posedge clk); #1;
        chk("idle_hold", {31'd0, busy}, 0);

        start_run(3'd0, 4'd7);
        collect();
        exp_d = '{13'h11A7, 13'h1F3B, 13'h01BC, 13'h122C, 13'h096A, 13'h1247, 13'h0410};
        exp_i = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
        check_seq("seq", 7);

        start_run(3'd5, 4'd4);
        collect();
        exp_d = '{13'h1247, 13'h0410, 13'h11A7, 13'h1F3B};
        exp_i = '{3'd5, 3'd6, 3'd0, 3'd1};
        check_seq("wrap", 4);

        start_run(3'd2, 4'd15);
        collect();
        exp_d = '{13'h01BC, 13'h122C, 13'h096A, 13'h1247, 13'h0410, 13'h11A7, 13'h1F3B};
        exp_i = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0, 3'd1};
        check_seq("clamp", 7);

        start_run(3'd0, 4'd7);
        chk("bp_w0", {19'd0, out_d}, 32'h11A7);
        @(posedge clk); #1;
        chk("bp_w1", {19'd0, out_d}, 32'h1F3B);
        @(posedge clk); #1;
        out_rdy = 1'b0;
        w[2] = 13'h0000;
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("bp_hold%0d", s), {19'd0, out_d}, 32'h01BC);
            chk($sformatf("bp_idx%0d", s), {29'd0, out_idx}, 2);
            @(posedge clk); #1;
        end
        out_rdy = 1'b1;
        collect();
        exp_d = '{13'h01BC, 13'h122C, 13'h096A, 13'h1247, 13'h0410};
        exp_i = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
        check_seq("bp", 5);
        load_words();

        start_run(3'd0, 4'd0);
        chk("zero_done", {31'd0, done}, 1);
        chk("zero_vld", {31'd0, out_vld}, 0);
        chk("zero_busy", {31'd0, busy}, 1);
        @(posedge clk); #1;
        chk("zero_end", {31'd0, done}, 0);
        chk("zero_vld2", {31'd0, out_vld}, 0);

        start_run(3'd7, 4'd2);
        collect();
        exp_d = '{13'h11A7, 13'h1F3B};
        exp_i = '{3'd0, 3'd1};
        check_seq("fi7", 2);

        start_run(3'd0, 4'd3);
        start = 1'b1;
        first_idx = 3'd4;
        num = 4'd1;
        collect();
        start = 1'b0;
        exp_d = '{13'h11A7, 13'h1F3B, 13'h01BC};
        exp_i = '{3'd0, 3'd1, 3'd2};
        check_seq("ign", 3);
        @(posedge clk); #1;
        chk("ign_noq", {31'd0, busy}, 0);

        start_run(3'd0, 4'd7);
        repeat (3) @(posedge clk);
        #1 rst_b = 1'b0;
        #1;
        chk("mid_rst_vld", {31'd0, out_vld}, 0);
        chk("mid_rst_d", {19'd0, out_d}, 0);
        chk("mid_rst_idx", {29'd0, out_idx}, 0);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_done", {31'd0, done}, 0);
        rst_b = 1'b1;
        @(posedge clk); #1;
        start_run(3'd3, 4'd1);
        collect();
        exp_d = '{13'h122C};
        exp_i = '{3'd3};
        check_seq("post_rst", 1);

        w[1] = 13'h0000;
        w[2] = 13'h0000;
        start_run(3'd0, 4'd4);
        collect();
`ifdef REGFL_RDR_SKIP_ZERO_EN
        exp_d = '{13'h11A7, 13'h122C};
        exp_i = '{3'd0, 3'd3};
`else
        exp_d = '{13'h11A7, 13'h0000, 13'h0000, 13'h122C};
        exp_i = '{3'd0, 3'd1, 3'd2, 3'd3};
`endif
        check_seq("zw", 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
